aq_local_reg_bank: RTL

- Local-bus register bank that sits directly downstream of the team's AXI4-Lite-to-local-bus slave bridge.
- Consumes LOCAL_CS/RNW/ADDR/BE/WDATA and produces LOCAL_ACK/LOCAL_RDATA.
- Provides an ID register, a sampled status register, a W1C interrupt status register with enable mask and IRQ output, and NUM_CTRL read/write control registers driving fabric logic.

---
 rtl/aq_local_reg_bank.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/aq_local_reg_bank.sv
// aq_local_reg_bank
// Local-bus register bank behind the AXI4-Lite-to-local-bus bridge.
// It holds an ID register, a sampled status register, a W1C interrupt status
// register with an enable mask and an IRQ output, and NUM_CTRL control registers.
// Each access is committed exactly once, on entry to the ACK state. The
// requester must drop LOCAL_CS before the bank will take another access.
module aq_local_reg_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_CTRL  = 4,
  parameter int          ACK_WAIT  = 0,
  parameter logic [31:0] ID_VALUE  = 32'hA0A0_0001
) (
  input  logic                     ARESETN,
  input  logic                     ACLK,
  input  logic                     LOCAL_CS,
  input  logic                     LOCAL_RNW,
  input  logic [31:0]              LOCAL_ADDR,
  input  logic [3:0]               LOCAL_BE,
  input  logic [31:0]              LOCAL_WDATA,
  output logic                     LOCAL_ACK,
  output logic [31:0]              LOCAL_RDATA,
  input  logic [31:0]              STATUS_IN,
  input  logic [31:0]              IRQ_SRC,
  output logic [NUM_CTRL*32-1:0]   CTRL_OUT,
  output logic                     IRQ
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // Expand the byte enables into a 32-bit bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
    end
    return m;
  endfunction

  logic [1:0]               state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     ack_q, ack_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [31:0]              status_q;
  logic [31:0]              irq_stat_q, irq_stat_d;
  logic [31:0]              irq_en_q, irq_en_d;
  logic                     irq_q, irq_d;
  logic [NUM_CTRL*32-1:0]   ctrl_q, ctrl_d;

  logic                     hit_s;
  logic [5:0]               word_idx_s;
  logic [31:0]              wmask_s;
  logic                     commit_s;
  logic                     wr_en_s;
  logic [31:0]              rd_mux_s;
  logic [31:0]              rd_ctrl_s;
  logic [31:0]              clr_s;
  logic                     unused_addr_lsb_s;

  // Address decode. The two address LSBs carry no meaning on this bank.
  assign hit_s             = (LOCAL_ADDR[31:8] == BASE_ADDR[31:8]);
  assign word_idx_s        = LOCAL_ADDR[7:2];
  assign wmask_s           = be_mask(LOCAL_BE);
  assign unused_addr_lsb_s = ^LOCAL_ADDR[1:0];

  // Access FSM. The wait counter is loaded with ACK_WAIT and is decremented until ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (LOCAL_CS) begin
          if (ACK_WAIT == 0) begin
            state_d = S_ACK;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(ACK_WAIT);
          end
        end else begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      S_WAIT: begin
        if (!LOCAL_CS) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_ACK;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        if (!LOCAL_CS) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_ACK;
        end
        cnt_d = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Commit the access only on the edge that enters ACK. A held ACK never commits again.
  assign commit_s = (state_d == S_ACK) && (state_q != S_ACK);
  assign wr_en_s  = commit_s && !LOCAL_RNW && hit_s;

  // Select the CTRL register that the current word index addresses.
  always_comb begin
    rd_ctrl_s = 32'h0;
    for (int n = 0; n < NUM_CTRL; n++) begin
      rd_ctrl_s = rd_ctrl_s | ((word_idx_s == 6'(n + 4)) ? ctrl_q[32*n +: 32] : 32'h0);
    end
  end

  // Read mux. A base miss or an unmapped offset reads as zero.
  always_comb begin
    rd_mux_s = 32'h0;
    if (hit_s) begin
      case (word_idx_s)
        6'd0:    rd_mux_s = ID_VALUE;
        6'd1:    rd_mux_s = status_q;
        6'd2:    rd_mux_s = irq_stat_q;
        6'd3:    rd_mux_s = irq_en_q;
        default: rd_mux_s = rd_ctrl_s;
      endcase
    end else begin
      rd_mux_s = 32'h0;
    end
  end

  // Next-state logic for the registers, including byte-masked writes and W1C clears.
  always_comb begin
    irq_en_d = irq_en_q;
    ctrl_d   = ctrl_q;
    clr_s    = 32'h0;
    if (wr_en_s) begin
      case (word_idx_s)
        6'd2: clr_s    = LOCAL_WDATA & wmask_s;
        6'd3: irq_en_d = (irq_en_q & ~wmask_s) | (LOCAL_WDATA & wmask_s);
        default: begin
          for (int n = 0; n < NUM_CTRL; n++) begin
            ctrl_d[32*n +: 32] = (word_idx_s == 6'(n + 4))
                               ? ((ctrl_q[32*n +: 32] & ~wmask_s) | (LOCAL_WDATA & wmask_s))
                               : ctrl_q[32*n +: 32];
          end
        end
      endcase
    end else begin
      clr_s = 32'h0;
    end
    // A set pulse wins over a clear in the same cycle.
    irq_stat_d = (irq_stat_q & ~clr_s) | IRQ_SRC;
    irq_d      = |(irq_stat_q & irq_en_q);
  end

  // Bus response. Read data is captured at commit, held while in ACK, and zero otherwise.
  always_comb begin
    ack_d = (state_d == S_ACK);
    if (commit_s) begin
      rdata_d = LOCAL_RNW ? rd_mux_s : 32'h0;
    end else if (state_d == S_ACK) begin
      rdata_d = rdata_q;
    end else begin
      rdata_d = 32'h0;
    end
  end

  // State and register storage. An asynchronous reset clears everything immediately.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      ack_q      <= 1'b0;
      rdata_q    <= 32'h0;
      status_q   <= 32'h0;
      irq_stat_q <= 32'h0;
      irq_en_q   <= 32'h0;
      irq_q      <= 1'b0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      status_q   <= STATUS_IN;
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign LOCAL_ACK   = ack_q;
  assign LOCAL_RDATA = rdata_q;
  assign CTRL_OUT    = ctrl_q;
  assign IRQ         = irq_q;

endmodule
